// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op/state types and constants for the RV32M multiply/divide unit
package muldiv_pkg;

  localparam int ITER = 32;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 RV32M multiply/divide unit for the execute stage
// One 64-bit accumulator serves both shift-add multiply and restoring divide.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic [XLEN-1:0] result,
  output logic            done,
  output logic            stall
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state;
  op_e               op;
  logic [5:0]        cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic              sign_res;
  logic              sign_a;

  logic            is_div, is_rem, signed_a, signed_b, neg_a, neg_b;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b, special_res;

  always_comb begin
    is_div   = funct3[2];
    is_rem   = funct3[2] & funct3[1];
    signed_a = is_div ? ~funct3[0] : (funct3 == MULH || funct3 == MULHSU);
    signed_b = is_div ? ~funct3[0] : (funct3 == MULH);
    neg_a    = signed_a & src_a[XLEN-1];
    neg_b    = signed_b & src_b[XLEN-1];
    mag_a    = neg_a ? -src_a : src_a;
    mag_b    = neg_b ? -src_b : src_b;
    div_zero = is_div && (src_b == '0);
    div_ovf  = is_div && !funct3[0] && (src_a == MIN_NEG) && (src_b == '1);
    if (div_zero) special_res = is_rem ? src_a : DIV0_QUOT;
    else          special_res = is_rem ? '0 : MIN_NEG;
  end

  // Multiply shifts right with the carry; divide shifts left bringing in the dividend MSB.
  logic [XLEN-1:0]   mul_addend, quot, remd, fin;
  logic [XLEN:0]     mul_sum, rem_sh, div_diff;
  logic [2*XLEN-1:0] acc_next, prod;

  always_comb begin
    mul_addend = acc[0] ? opnd : '0;
    mul_sum    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
    rem_sh     = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff   = rem_sh - {1'b0, opnd};
    if (!op[2])              acc_next = {mul_sum, acc[XLEN-1:1]};
    else if (div_diff[XLEN]) acc_next = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    else                     acc_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    prod = sign_res ? -acc_next : acc_next;
    quot = sign_res ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
    remd = sign_a ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
    case (op)
      MUL:                 fin = prod[XLEN-1:0];
      MULH, MULHSU, MULHU: fin = prod[2*XLEN-1:XLEN];
      DIV, DIVU:           fin = quot;
      default:             fin = remd;
    endcase
  end

  assign stall = (state == IDLE && start && !flush) || state == CALC;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op       <= MUL;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      sign_res <= 1'b0;
      sign_a   <= 1'b0;
      result   <= '0;
      done     <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (div_zero || div_ovf) begin
              result <= special_res;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              op       <= op_e'(funct3);
              sign_res <= neg_a ^ neg_b;
              sign_a   <= neg_a;
              cnt      <= '0;
              acc      <= is_div ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
              opnd     <= is_div ? mag_b : mag_a;
              state    <= CALC;
            end
          end
        end
        CALC: begin
          acc <= acc_next;
          if (cnt == 6'(ITER - 1)) begin
            cnt    <= '0;
            result <= fin;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic [31:0] result;
  logic        done;
  logic        stall;

  int n_cmp = 0;
  int n_bad = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .flush  (flush),
    .funct3 (funct3),
    .src_a  (src_a),
    .src_b  (src_b),
    .result (result),
    .done   (done),
    .stall  (stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && (b == 32'd0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q;
    logic [63:0] p;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = '0;
    q  = 0;
    case (f3)
      F_MUL:    begin p = sa * sb; return p[31:0]; end
      F_MULH:   begin p = sa * sb; return p[63:32]; end
      F_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
      F_MULHU:  begin p = ua * ub; return p[63:32]; end
      F_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = sa / sb;
        return q[31:0];
      end
      F_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        q = sa % sb;
        return q[31:0];
      end
      F_DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Called just after a rising edge; that cycle is N. Leaves start high through the done cycle.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int lat, stall_cnt, done_at;
    logic [31:0] exp, got;
    exp = ref_result(f3, a, b);
    lat = is_special(f3, a, b) ? 1 : 33;
    funct3 = f3;
    src_a  = a;
    src_b  = b;
    start  = 1'b1;
    stall_cnt = 0;
    done_at   = -1;
    got       = '0;
    for (int k = 0; k < 40 && done_at < 0; k++) begin
      @(negedge clk);
      stall_cnt += int'(stall);
      if (done) begin
        done_at = k;
        got     = result;
      end
      tick();
    end
    start = 1'b0;
    check({tag, "_lat"}, 64'(done_at), 64'(lat));
    check({tag, "_stall"}, 64'(stall_cnt), 64'(lat));
    check({tag, "_res"}, {32'd0, got}, {32'd0, exp});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'(32'($urandom_range(0, 20)));
      default: return 32'($urandom());
    endcase
  endfunction

  initial begin
    int spurious;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_result", {32'd0, result}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_stall", {63'd0, stall}, 64'd0);
    tick();
    while (($time / 10) < 10) tick();

    run_op("mul_neg", F_MUL, 32'd7, 32'hFFFF_FFFD);
    tick();
    run_op("mulh_min", F_MULH, 32'h8000_0000, 32'h8000_0000);
    run_op("mulhu_max", F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulhsu_max", F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_neg", F_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op("rem_neg", F_REM, 32'hFFFF_FFF9, 32'd2);
    run_op("divu", F_DIVU, 32'd100, 32'd7);
    run_op("remu", F_REMU, 32'd100, 32'd7);
    run_op("div_by0", F_DIV, 32'd5, 32'd0);
    run_op("rem_by0", F_REM, 32'd5, 32'd0);
    run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf", F_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    @(negedge clk);
    check("b2b_idle_stall", {63'd0, stall}, 64'd0);
    check("b2b_idle_done", {63'd0, done}, 64'd0);
    tick();

    // Flush mid-divide, then a fresh divide two cycles later.
    funct3 = F_DIV; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    repeat (10) tick();
    flush = 1'b1; start = 1'b0;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flush_stall", {63'd0, stall}, 64'd0);
    check("flush_done", {63'd0, done}, 64'd0);
    tick();
    run_op("divu_after_flush", F_DIVU, 32'd9, 32'd3);

    // start together with flush in IDLE is not accepted.
    funct3 = F_MUL; src_a = 32'd3; src_b = 32'd3; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("flush_start_stall", {63'd0, stall}, 64'd0);
    tick();
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_start_next_stall", {63'd0, stall}, 64'd0);
    tick();

    // Flush in DONE still shows the done pulse that cycle.
    funct3 = F_DIVU; src_a = 32'd5; src_b = 32'd0; start = 1'b1;
    tick();
    start = 1'b0; flush = 1'b1;
    @(negedge clk);
    check("flush_done_pulse", {63'd0, done}, 64'd1);
    check("flush_done_res", {32'd0, result}, 64'hFFFF_FFFF);
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flush_done_after", {63'd0, done}, 64'd0);
    tick();

    // Reset mid-operation aborts without a done pulse.
    funct3 = F_DIV; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
    repeat (5) tick();
    rst = 1'b1; start = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_result", {32'd0, result}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_stall", {63'd0, stall}, 64'd0);
    spurious = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      spurious += int'(done) + int'(stall);
    end
    check("midrst_quiet", 64'(spurious), 64'd0);
    tick();

    // Back-to-back: second op starts the cycle after the first one's DONE.
    run_op("b2b_mul", F_MUL, 32'h0001_0003, 32'h0000_0105);
    run_op("b2b_remu", F_REMU, 32'd10, 32'd4);
    tick();

    for (int i = 0; i < 40; i++) begin
      logic [2:0] f3;
      logic [31:0] a, b;
      f3 = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      run_op($sformatf("rnd%0d_f%0d", i, f3), f3, a, b);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, directly upstream of the E->M pipeline register.
- Accepts one M-extension op per start, holds the pipeline via stall while computing, and presents a 32-bit result that the E->M register captures as the ALU result.
- Covers MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Radix-2: 32 iterations for all normal ops; divide special cases finish early.

Parameters:
- XLEN, 32, operand and result width. Only 32 is supported.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  E-stage instruction is an M-extension op (opcode 0110011, funct7 0000001).
- flush  input  1  E-stage instruction is being killed (branch taken or hazard flush).
- funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- src_a  input  32  rs1 operand, forwarded.
- src_b  input  32  rs2 operand, forwarded.
- result  output  32  result; valid only while done=1.
- done  output  1  one-cycle pulse; result valid.
- stall  output  1  freeze PC, fetch/decode and D->E registers; insert a bubble downstream.

Behaviour:
- Reset: state IDLE, result=0, done=0, stall=0, counter=0, internal accumulators=0. Reset mid-operation aborts the op and does not assert done.
- States and transitions:
  - IDLE: start && !flush moves to CALC, or to DONE for a divide special case.
  - CALC: 32 cycles, then DONE.
  - DONE: one cycle, then IDLE. start during DONE is ignored, because it is the same instruction still sitting in E.
- stall = (state==IDLE && start && !flush) || state==CALC. stall is combinational and low in DONE, so the pipeline advances that cycle and the E->M register samples result.
- Latency, start high in cycle N:
  - stall high cycles N..N+32.
  - done=1 in cycle N+33.
  - Back-to-back ops: a new start in cycle N+34 is accepted from IDLE.
- Operand latch on accept:
  - Latch funct3 and the operand magnitudes; record result sign.
  - Signed operands: DIV/REM/MULH both; MULHSU src_a only.
  - Magnitude = two's complement negation if the signed operand is negative.
  - 0x80000000 magnitude is 0x80000000, treated as an unsigned 33rd-bit-safe value.
- Multiply:
  - 64-bit shift-add: each CALC cycle adds the multiplicand when the multiplier LSB is 1, then shifts.
  - Negate the 64-bit product if the signs differ.
  - MUL takes bits [31:0]; MULH, MULHSU and MULHU take bits [63:32].
- Divide:
  - Restoring division: each cycle shifts the 32-bit remainder in with the dividend MSB, subtracts the divisor, and sets the quotient bit if the result is non-negative.
  - Quotient sign = sign_a XOR sign_b. Remainder sign = sign_a.
- Divide special cases, resolved in IDLE with done in cycle N+1 and stall only in cycle N:
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give src_a.
  - DIV or REM with src_a=0x80000000 and src_b=0xFFFFFFFF: quotient 0x80000000, remainder 0.
- Sign fix-up and the final result register are written on the CALC->DONE edge. result holds its value outside DONE but is don't-care there.
- Flush:
  - flush in any state forces IDLE next cycle; done=0 and stall=0 in that cycle.
  - flush together with start in IDLE means the op is not accepted.
  - flush in DONE does not block the done pulse of the current cycle; the E->M register discards it.
- Priority: rst > flush > normal operation.
- Counter is 6 bits and counts 0..31. Wrap from 31 exits CALC.

Decomposition:
- Package muldiv_pkg holds:
  - typedef enum for funct3 ops: MUL..REMU.
  - typedef enum for state: IDLE, CALC, DONE.
  - localparam ITER=32.
  - DIV0_QUOT=32'hFFFF_FFFF.
- Single module, no sub-module. The datapath is one shared 64-bit accumulator plus a 32-bit operand register, so splitting adds no value.

Test Plan:
- MUL src_a=7, src_b=0xFFFFFFFD, start in cycle 10 -> stall 10..42, done in 43 with result 0xFFFFFFEB.
- High products:
  - MULH 0x80000000*0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- Division:
  - DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD.
  - REM 0xFFFFFFF9/2 -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14.
  - REMU 100/7 -> 2.
  - Each has done at N+33.
- Special cases, each with done at N+1 and stall only at N:
  - DIV 5/0 -> 0xFFFFFFFF.
  - REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM of the same operands -> 0.
- Flush and reset:
  - flush at N+10 of a DIV -> IDLE at N+11, no done pulse.
  - A following DIVU 9/3 started at N+12 -> 3 at N+45.
  - rst at N+5 -> all outputs 0 next cycle.
- Back-to-back: MUL started at N, then REMU 10/4 held high from N+34 -> done at N+33 (MUL) and N+67 (result 2). start held in DONE at N+33 does not retrigger.
